// File: rtl/uart_rx.sv
// Oversampling UART receiver: 2-FF line synchroniser, mid-bit start validation and
// data sampling, stop-bit check, one-deep valid/read holding register.
module uart_rx #(
  parameter int unsigned DATAWIDTH = 8,
  parameter int unsigned SB_TICK   = 16
) (
  input  logic                 clk,
  input  logic                 rx_rst_n,
  input  logic                 rx_en,
  input  logic                 s_tick,
  input  logic                 rx,
  input  logic                 rx_rd,
  output logic [DATAWIDTH-1:0] dout,
  output logic                 rx_valid,
  output logic                 rx_done,
  output logic                 rx_busy,
  output logic                 frame_err,
  output logic                 overrun_err
);

  localparam int unsigned S_W = $clog2(SB_TICK);
  localparam int unsigned B_W = $clog2(DATAWIDTH) + 1;

  localparam logic [S_W-1:0] S_HALF = S_W'(SB_TICK / 2 - 1);
  localparam logic [S_W-1:0] S_LAST = S_W'(SB_TICK - 1);
  localparam logic [B_W-1:0] B_LAST = B_W'(DATAWIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t               state;
  logic                 rx_meta;
  logic                 rxs;
  logic                 armed;
  logic [S_W-1:0]       s_cnt;
  logic [B_W-1:0]       bit_cnt;
  logic [DATAWIDTH-1:0] shift;

  // Line synchroniser, reset to the idle (high) level
  always_ff @(posedge clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      state       <= IDLE;
      armed       <= 1'b1;
      s_cnt       <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      dout        <= '0;
      rx_valid    <= 1'b0;
      rx_done     <= 1'b0;
      rx_busy     <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      rx_done   <= 1'b0;
      frame_err <= 1'b0;

      // A read clears first so that a frame landing in the same clock wins
      if (rx_rd) begin
        rx_valid    <= 1'b0;
        overrun_err <= 1'b0;
      end

      if (!rx_en) begin
        state   <= IDLE;
        rx_busy <= 1'b0;
        s_cnt   <= '0;
        bit_cnt <= '0;
        if (rxs) armed <= 1'b1;
      end else begin
        unique case (state)
          IDLE: begin
            if (armed && !rxs) begin
              state   <= START;
              rx_busy <= 1'b1;
              s_cnt   <= '0;
              armed   <= 1'b0;
            end else if (rxs) begin
              armed <= 1'b1;
            end
          end

          START: begin
            if (s_tick) begin
              if (s_cnt == S_HALF) begin
                s_cnt <= '0;
                if (!rxs) begin
                  state   <= DATA;
                  bit_cnt <= '0;
                end else begin
                  state   <= IDLE;
                  rx_busy <= 1'b0;
                end
              end else begin
                s_cnt <= s_cnt + S_W'(1);
              end
            end
          end

          DATA: begin
            if (s_tick) begin
              if (s_cnt == S_LAST) begin
                s_cnt <= '0;
                shift <= {rxs, shift[DATAWIDTH-1:1]};
                if (bit_cnt == B_LAST) state <= STOP;
                else bit_cnt <= bit_cnt + B_W'(1);
              end else begin
                s_cnt <= s_cnt + S_W'(1);
              end
            end
          end

          STOP: begin
            if (s_tick) begin
              if (s_cnt == S_LAST) begin
                s_cnt   <= '0;
                state   <= IDLE;
                rx_busy <= 1'b0;
                if (rxs) begin
                  dout     <= shift;
                  rx_done  <= 1'b1;
                  rx_valid <= 1'b1;
                  if (rx_valid && !rx_rd) overrun_err <= 1'b1;
                end else begin
                  frame_err <= 1'b1;
                end
              end else begin
                s_cnt <= s_cnt + S_W'(1);
              end
            end
          end

          default: begin
            state   <= IDLE;
            rx_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: table of frames checked via a pulse scoreboard, plus glitch,
// mid-frame reset and mid-frame disable sequences.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rx_rst_n = 1'b0;
  logic       rx_en = 1'b1;
  logic       s_tick = 1'b0;
  logic       rx = 1'b1;
  logic       rx_rd = 1'b0;
  logic [7:0] dout;
  logic       rx_valid, rx_done, rx_busy, frame_err, overrun_err;

  uart_rx #(.DATAWIDTH(8), .SB_TICK(16)) dut (
    .clk(clk), .rx_rst_n(rx_rst_n), .rx_en(rx_en), .s_tick(s_tick), .rx(rx),
    .rx_rd(rx_rd), .dout(dout), .rx_valid(rx_valid), .rx_done(rx_done),
    .rx_busy(rx_busy), .frame_err(frame_err), .overrun_err(overrun_err)
  );

  always #5 clk = ~clk;

  int unsigned div  = 1;
  int unsigned tcnt = 0;
  int          cyc  = 0;
  int          start_cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Oversample tick: one pulse every div clocks
  always @(negedge clk) begin
    if (tcnt + 1 >= div) tcnt = 0;
    else tcnt = tcnt + 1;
    s_tick = (tcnt == 0);
  end

  typedef struct {
    logic [7:0] data;
    logic       ferr;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every rx_done / frame_err pulse must match the next expected frame
  always @(negedge clk) begin
    if (rx_rst_n && (rx_done === 1'b1 || frame_err === 1'b1)) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {30'd0, rx_done, frame_err}, 32'd0);
      end else begin
        e_mon = sb.pop_front();
        chk("pulse_kind", {30'd0, rx_done, frame_err}, e_mon.ferr ? 32'd1 : 32'd2);
        if (!e_mon.ferr) begin
          chk("sb_dout", {24'd0, dout}, {24'd0, e_mon.data});
          if (div == 1) chk("latency_le_170", {31'd0, (cyc - start_cyc) <= 170}, 32'd1);
        end
      end
    end
  end

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    int unsigned bt = 16 * div;
    sb.push_back('{data: d, ferr: !stop_bit});
    @(negedge clk);
    rx = 1'b0;
    start_cyc = cyc;
    repeat (bt) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (bt) @(negedge clk);
    end
    rx = stop_bit;
    repeat (bt) @(negedge clk);
    if (!stop_bit) begin
      repeat (30) @(negedge clk);
      chk("break_no_retrigger", {31'd0, rx_busy}, 32'd0);
      repeat (10) @(negedge clk);
    end
    rx = 1'b1;
    repeat (4) @(negedge clk);
    chk("sb_drained", sb.size(), 32'd0);
  endtask

  // Start bit plus nbits data bits, then half of bit nbits; caller aborts the frame
  task automatic send_partial(input logic [7:0] d, input int nbits);
    int unsigned bt = 16 * div;
    @(negedge clk);
    rx = 1'b0;
    repeat (bt) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      rx = d[i];
      repeat (bt) @(negedge clk);
    end
    rx = d[nbits];
    repeat (bt / 2) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0]  data;
    logic        stop;
    int unsigned tdiv;
    logic        rd;
    logic [7:0]  exp_dout;
    logic        exp_valid;
    logic        exp_ovr;
  } vec_t;

  vec_t tbl[7];

  initial begin
    tbl[0] = '{8'hA5, 1'b1, 1, 1'b1, 8'hA5, 1'b1, 1'b0};
    tbl[1] = '{8'h3C, 1'b0, 1, 1'b0, 8'hA5, 1'b0, 1'b0};
    tbl[2] = '{8'h11, 1'b1, 1, 1'b0, 8'h11, 1'b1, 1'b0};
    tbl[3] = '{8'h22, 1'b1, 1, 1'b1, 8'h22, 1'b1, 1'b1};
    tbl[4] = '{8'h00, 1'b1, 3, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[5] = '{8'hFF, 1'b1, 3, 1'b0, 8'hFF, 1'b1, 1'b1};
    tbl[6] = '{8'h80, 1'b1, 3, 1'b1, 8'h80, 1'b1, 1'b1};

    repeat (3) @(negedge clk);
    chk("rst_dout", {24'd0, dout}, 32'd0);
    chk("rst_flags", {26'd0, rx_valid, rx_done, rx_busy, frame_err, overrun_err, 1'b0}, 32'd0);
    rx_rst_n = 1'b1;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      div = tbl[i].tdiv;
      send_frame(tbl[i].data, tbl[i].stop);
      chk($sformatf("v%0d_dout", i), {24'd0, dout}, {24'd0, tbl[i].exp_dout});
      chk($sformatf("v%0d_valid", i), {31'd0, rx_valid}, {31'd0, tbl[i].exp_valid});
      chk($sformatf("v%0d_ovr", i), {31'd0, overrun_err}, {31'd0, tbl[i].exp_ovr});
      if (tbl[i].rd) begin
        rx_rd = 1'b1;
        @(negedge clk);
        rx_rd = 1'b0;
        chk($sformatf("v%0d_rd_clear", i), {30'd0, rx_valid, overrun_err}, 32'd0);
      end
    end

    // Short low glitch on an idle line must be rejected at the start-bit midpoint
    div = 1;
    @(negedge clk);
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    chk("glitch_busy_rise", {31'd0, rx_busy}, 32'd1);
    repeat (9) @(negedge clk);
    chk("glitch_busy_drop", {31'd0, rx_busy}, 32'd0);
    repeat (20) @(negedge clk);

    // Reset during bit 4: everything returns to reset values
    send_partial(8'h5A, 4);
    chk("pre_rst_busy", {31'd0, rx_busy}, 32'd1);
    rx_rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_dout", {24'd0, dout}, 32'd0);
    chk("midrst_flags", {28'd0, rx_valid, rx_busy, overrun_err, frame_err}, 32'd0);
    rx = 1'b1;
    rx_rst_n = 1'b1;
    repeat (40) @(negedge clk);
    send_frame(8'h5A, 1'b1);
    chk("after_rst_dout", {24'd0, dout}, 32'h5A);
    chk("after_rst_valid", {31'd0, rx_valid}, 32'd1);

    // Disable during bit 4: partial frame dropped, holding register untouched
    send_partial(8'h5A, 4);
    chk("pre_dis_busy", {31'd0, rx_busy}, 32'd1);
    rx_en = 1'b0;
    repeat (2) @(negedge clk);
    chk("dis_busy", {31'd0, rx_busy}, 32'd0);
    chk("dis_hold", {23'd0, dout, rx_valid}, {23'd0, 8'h5A, 1'b1});
    rx = 1'b1;
    repeat (20) @(negedge clk);
    rx_en = 1'b1;
    repeat (20) @(negedge clk);
    send_frame(8'h5A, 1'b1);
    chk("reen_dout", {24'd0, dout}, 32'h5A);
    chk("reen_overrun", {31'd0, overrun_err}, 32'd1);

    chk("sb_final", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
